// File: rtl/ascon_perm_sequencer.sv
// Round sequencer for the ASCON permutation datapath: issues p^a / p^b round
// schedules with registered controls. Optional stall input under ASCON_SEQ_HOLD_EN.
module ascon_perm_sequencer #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       mode_i,
`ifdef ASCON_SEQ_HOLD_EN
    input  logic       hold_i,
`endif
    output logic [3:0] round_o,
    output logic       enable_o,
    output logic       sel_mux_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] FIRST_A    = 4'(12 - ROUNDS_A);
    localparam logic [3:0] FIRST_B    = 4'(12 - ROUNDS_B);
    localparam logic [3:0] LAST_ROUND = 4'd11;

    state_t state_r;
    logic   hold_s;

`ifdef ASCON_SEQ_HOLD_EN
    assign hold_s = hold_i;
`else
    assign hold_s = 1'b0;
`endif

    // Sequencer state and all registered datapath controls.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_r   <= ST_IDLE;
            round_o   <= 4'd0;
            enable_o  <= 1'b0;
            sel_mux_o <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        // The captured mode lives on as the starting round index.
                        state_r   <= ST_FIRST;
                        round_o   <= mode_i ? FIRST_B : FIRST_A;
                        enable_o  <= 1'b1;
                        sel_mux_o <= 1'b0;
                        busy_o    <= 1'b1;
                        done_o    <= 1'b0;
                    end else begin
                        state_r   <= ST_IDLE;
                        round_o   <= 4'd0;
                        enable_o  <= 1'b0;
                        sel_mux_o <= 1'b0;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b0;
                    end
                end
                ST_FIRST, ST_RUN: begin
                    if (hold_s) begin
                        // Round shown was written at the stall edge; keep it, block writes.
                        state_r   <= state_r;
                        round_o   <= round_o;
                        enable_o  <= 1'b0;
                        sel_mux_o <= sel_mux_o;
                        busy_o    <= 1'b1;
                        done_o    <= 1'b0;
                    end else if (round_o == LAST_ROUND) begin
                        state_r   <= ST_DONE;
                        round_o   <= LAST_ROUND;
                        enable_o  <= 1'b0;
                        sel_mux_o <= 1'b1;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                    end else begin
                        state_r   <= ST_RUN;
                        round_o   <= round_o + 4'd1;
                        enable_o  <= 1'b1;
                        sel_mux_o <= 1'b1;
                        busy_o    <= 1'b1;
                        done_o    <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    round_o   <= 4'd0;
                    enable_o  <= 1'b0;
                    sel_mux_o <= 1'b0;
                    busy_o    <= 1'b0;
                    done_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Self-checking bench for ascon_perm_sequencer: directed scenarios plus random
// start/mode/hold traffic compared each cycle against a schedule-list model.
module tb_ascon_perm_sequencer;

    localparam int ROUNDS_A = 12;
    localparam int ROUNDS_B = 6;
`ifdef ASCON_SEQ_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] r;
        logic       en;
        logic       sel;
        logic       busy;
        logic       done;
    } outs_t;

    logic       clk;
    logic       resetb;
    logic       start;
    logic       mode;
`ifdef ASCON_SEQ_HOLD_EN
    logic       hold;
`endif
    logic [3:0] round_o;
    logic       enable_o;
    logic       sel_mux_o;
    logic       busy_o;
    logic       done_o;

    int    n_vec;
    int    n_err;
    int    cyc;
    outs_t cur;
    outs_t sched_q[$];

    ascon_perm_sequencer #(
        .ROUNDS_A (ROUNDS_A),
        .ROUNDS_B (ROUNDS_B)
    ) dut (
        .clock_i   (clk),
        .resetb_i  (resetb),
        .start_i   (start),
        .mode_i    (mode),
`ifdef ASCON_SEQ_HOLD_EN
        .hold_i    (hold),
`endif
        .round_o   (round_o),
        .enable_o  (enable_o),
        .sel_mux_o (sel_mux_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got round=%0d en=%b sel=%b busy=%b done=%b expected round=%0d en=%b sel=%b busy=%b done=%b",
                     tag, cyc, obs[7:4], obs[3], obs[2], obs[1], obs[0],
                     exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Reference: a start builds the full list of per-cycle outputs; each edge pops one.
    task automatic model_step(input logic st, input logic md, input logic hd);
        int rr;
        int first;
        if (!cur.busy) begin
            if (st) begin
                rr    = md ? ROUNDS_B : ROUNDS_A;
                first = 12 - rr;
                sched_q.delete();
                for (int k = first; k <= 11; k++)
                    sched_q.push_back(outs_t'{r: 4'(k), en: 1'b1, sel: (k != first),
                                              busy: 1'b1, done: 1'b0});
                sched_q.push_back(outs_t'{r: 4'd11, en: 1'b0, sel: 1'b1, busy: 1'b0, done: 1'b1});
                cur = sched_q.pop_front();
            end else begin
                cur = '0;
            end
        end else if (hd && HOLD_EN) begin
            cur.en = 1'b0;
        end else begin
            cur = sched_q.pop_front();
        end
    endtask

    task automatic step(input logic st, input logic md, input logic hd);
        start = st;
        mode  = md;
`ifdef ASCON_SEQ_HOLD_EN
        hold  = hd;
`endif
        model_step(st, md, hd);
        @(negedge clk);
        cyc++;
        check_eq("outs", {round_o, enable_o, sel_mux_o, busy_o, done_o}, cur);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        cyc    = 0;
        cur    = '0;
        resetb = 1'b0;
        start  = 1'b0;
        mode   = 1'b0;
`ifdef ASCON_SEQ_HOLD_EN
        hold   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_eq("reset", {round_o, enable_o, sel_mux_o, busy_o, done_o}, 8'h00);
        resetb = 1'b1;

        // p^a full run, then idle.
        step(1'b1, 1'b0, 1'b0);
        repeat (14) step(1'b0, 1'b0, 1'b0);

        // p^b, then back-to-back p^a requested in the DONE cycle.
        step(1'b1, 1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        // start/mode toggling during the p^a run must be ignored.
        for (int i = 0; i < 12; i++) step(i[0], ~i[0], 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);

`ifdef ASCON_SEQ_HOLD_EN
        // p^b with a 3-cycle stall at round 8.
        step(1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0, 1'b0);
`endif

        // Asynchronous reset at round 7 of p^a.
        step(1'b1, 1'b0, 1'b0);
        while (cur.r != 4'd7) step(1'b0, 1'b0, 1'b0);
        #2 resetb = 1'b0;
        #1 check_eq("async_rst", {round_o, enable_o, sel_mux_o, busy_o, done_o}, 8'h00);
        cur = '0;
        sched_q.delete();
        @(negedge clk);
        check_eq("rst_hold", {round_o, enable_o, sel_mux_o, busy_o, done_o}, 8'h00);
        resetb = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)),
                 HOLD_EN && ($urandom_range(0, 9) < 2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
